// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request agent.
package rr_pkg;

  localparam int unsigned N_CH = 4;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_REQ  = 2'd1,
    CH_XFER = 2'd2,
    CH_REL  = 2'd3
  } ch_state_e;

  // Bits needed to index 0..value-1; never less than 1 so vectors stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    int unsigned span;
    w    = 1;
    span = 2;
    while (span < value) begin
      span = span * 2;
      w    = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_req_channel.sv
// One requester channel: pending-job counter, request FSM and beat counter.
module rr_req_channel
  import rr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pend_i,
  input  logic             gnt_i,
  input  logic             gnt_legal_i,
  output logic             req,
  output logic [CNT_W-1:0] cnt,
  output logic             xfer_nxt_c,
  output logic [IDX_W-1:0] idx_nxt_c,
  output logic             ovf_hit_c,
  output logic             gnt_err_c
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ch_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             dec;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dec       = 1'b0;
    ovf_hit_c = 1'b0;
    gnt_err_c = 1'b0;

    case (state_q)
      CH_IDLE: begin
        gnt_err_c = gnt_i;
        if (cnt_q != '0) state_d = CH_REQ;
      end
      CH_REQ: begin
        if (gnt_i && gnt_legal_i) begin
          state_d = CH_XFER;
          idx_d   = '0;
        end
      end
      CH_XFER: begin
        // A grant withdrawn mid-burst aborts without consuming the job.
        if (!gnt_i) begin
          state_d   = CH_REL;
          gnt_err_c = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = CH_REL;
          dec     = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CH_REL: begin
        gnt_err_c = gnt_i;
        state_d   = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase

    if (state_d != CH_XFER) idx_d = '0;

    // Simultaneous add and retire cancel out.
    if (pend_i && !dec) begin
      if (cnt_q == CNT_MAX) ovf_hit_c = 1'b1;
      else                  cnt_d     = cnt_q + 1'b1;
    end else if (dec && !pend_i) begin
      cnt_d = cnt_q - 1'b1;
    end

    req_d      = (state_d == CH_REQ) || (state_d == CH_XFER);
    xfer_nxt_c = (state_d == CH_XFER);
    idx_nxt_c  = idx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign req = req_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/rr_request_agent.sv
// Requester front end for a 4-way round-robin arbiter: per-channel job queues,
// REQ generation, granted burst on a shared beat bus and grant legality checks.
module rr_request_agent
  import rr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0]             pend_in,
  input  logic [N_CH-1:0]             GNT,
  output logic [N_CH-1:0]             REQ,
  output logic                        beat_valid,
  output logic [1:0]                  beat_ch,
  output logic [clog2(BURST_LEN)-1:0] beat_idx,
  output logic                        burst_done,
  output logic [N_CH*CNT_W-1:0]       pend_cnt,
  output logic                        ovf_err,
  output logic                        proto_err
);

  localparam int unsigned IDX_W = clog2(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  logic [N_CH-1:0]  xfer_nxt;
  logic [IDX_W-1:0] idx_nxt [N_CH];
  logic [N_CH-1:0]  ovf_hit;
  logic [N_CH-1:0]  gnt_err;
  logic             gnt_multi_c;

  logic             beat_valid_q, beat_valid_d;
  logic [1:0]       beat_ch_q, beat_ch_d;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic             burst_done_q, burst_done_d;
  logic             ovf_err_q, ovf_err_d;
  logic             proto_err_q, proto_err_d;

  // More than one grant bit set is never legal and never starts a burst.
  assign gnt_multi_c = (GNT & (GNT - N_CH'(1))) != '0;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rr_req_channel #(
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W),
      .IDX_W     (IDX_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .pend_i      (pend_in[i]),
      .gnt_i       (GNT[i]),
      .gnt_legal_i (!gnt_multi_c),
      .req         (REQ[i]),
      .cnt         (pend_cnt[i*CNT_W +: CNT_W]),
      .xfer_nxt_c  (xfer_nxt[i]),
      .idx_nxt_c   (idx_nxt[i]),
      .ovf_hit_c   (ovf_hit[i]),
      .gnt_err_c   (gnt_err[i])
    );
  end

  // Beat bus mux; at most one channel is ever in transfer.
  always_comb begin
    beat_valid_d = 1'b0;
    beat_ch_d    = '0;
    beat_idx_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (xfer_nxt[i]) begin
        beat_valid_d = 1'b1;
        beat_ch_d    = 2'(i);
        beat_idx_d   = idx_nxt[i];
      end
    end
    burst_done_d = beat_valid_d && (beat_idx_d == LAST_IDX);
    ovf_err_d    = ovf_err_q | (|ovf_hit);
    proto_err_d  = proto_err_q | gnt_multi_c | (|gnt_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_valid_q <= 1'b0;
      beat_ch_q    <= '0;
      beat_idx_q   <= '0;
      burst_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      beat_valid_q <= beat_valid_d;
      beat_ch_q    <= beat_ch_d;
      beat_idx_q   <= beat_idx_d;
      burst_done_q <= burst_done_d;
      ovf_err_q    <= ovf_err_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign beat_valid = beat_valid_q;
  assign beat_ch    = beat_ch_q;
  assign beat_idx   = beat_idx_q;
  assign burst_done = burst_done_q;
  assign ovf_err    = ovf_err_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_rr_request_agent.sv
// Bench for rr_request_agent: timestamp-based reference model plus a round-robin arbiter model.
module tb_rr_request_agent;

  localparam int L       = 4;
  localparam int CNT_MAX = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pend_in, GNT, REQ;
  logic        beat_valid, burst_done, ovf_err, proto_err;
  logic [1:0]  beat_ch, beat_idx;
  logic [11:0] pend_cnt;

  rr_request_agent #(.BURST_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .pend_in(pend_in), .GNT(GNT), .REQ(REQ),
    .beat_valid(beat_valid), .beat_ch(beat_ch), .beat_idx(beat_idx),
    .burst_done(burst_done), .pend_cnt(pend_cnt), .ovf_err(ovf_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Model: counts plus the cycle numbers at which REQ rises, the burst starts
  // and the channel may next request (-1 = not scheduled).
  int m_cnt [4];
  int m_req_at [4];
  int m_beat0 [4];
  int m_idle_from [4];
  bit m_ovf, m_proto;

  int arb_owner = -1;
  int arb_last  = 3;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_req_at[i] = -1; m_beat0[i] = -1; m_idle_from[i] = cyc + 1;
    end
    m_ovf = 0; m_proto = 0;
  endtask

  task automatic model_update(input logic [3:0] p, input logic [3:0] g);
    int c;
    int n;
    bit legal, req_now, dec;
    c = cyc;
    legal = ($countones(g) == 1);
    if ($countones(g) > 1) m_proto = 1;
    for (int i = 0; i < 4; i++) begin
      req_now = (m_req_at[i] >= 0) && (c >= m_req_at[i]);
      dec = 0;
      if (g[i] && !req_now) m_proto = 1;
      if (m_beat0[i] >= 0 && c >= m_beat0[i]) begin
        if (!g[i]) m_proto = 1;
        else if (c == m_beat0[i] + L - 1) dec = 1;
        if (!g[i] || dec) begin
          m_req_at[i] = -1; m_beat0[i] = -1; m_idle_from[i] = c + 2;
        end
      end else if (req_now) begin
        if (g[i] && legal) m_beat0[i] = c + 1;
      end else if (c >= m_idle_from[i] && m_cnt[i] != 0) begin
        m_req_at[i] = c + 1;
      end
      n = m_cnt[i] + int'(p[i]) - int'(dec);
      if (n > CNT_MAX) begin m_ovf = 1; n = CNT_MAX; end
      m_cnt[i] = n;
    end
  endtask

  function automatic logic [23:0] exp_vec();
    logic [3:0] r; logic bv; logic [1:0] ch, idx; logic bd; logic [11:0] pc;
    r = '0; bv = 0; ch = '0; idx = '0; bd = 0; pc = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = (m_req_at[i] >= 0) && (cyc >= m_req_at[i]);
      if (m_beat0[i] >= 0 && cyc >= m_beat0[i] && cyc < m_beat0[i] + L) begin
        bv = 1; ch = 2'(i); idx = 2'(cyc - m_beat0[i]); bd = (cyc - m_beat0[i] == L - 1);
      end
      pc[i*3 +: 3] = 3'(m_cnt[i]);
    end
    return {r, bv, ch, idx, bd, pc, m_ovf, m_proto};
  endfunction

  function automatic logic [23:0] act_vec();
    return {REQ, beat_valid, beat_ch, beat_idx, burst_done, pend_cnt, ovf_err, proto_err};
  endfunction

  task automatic step(input logic r, input logic [3:0] p, input logic [3:0] g);
    rst_n = r; pend_in = p; GNT = g;
    @(posedge clk);
    if (!r) model_reset();
    else    model_update(p, g);
    cyc++;
    @(negedge clk);
  endtask

  task automatic arb_reset();
    arb_owner = -1; arb_last = 3;
  endtask

  // Round-robin arbiter: hold the owner while it requests, else rotate.
  task automatic arb(output logic [3:0] g);
    int j;
    g = '0;
    if (!(arb_owner >= 0 && REQ[arb_owner])) begin
      arb_owner = -1;
      for (int k = 1; k <= 4; k++) begin
        j = (arb_last + k) % 4;
        if (arb_owner < 0 && REQ[j]) begin arb_owner = j; arb_last = j; end
      end
    end
    if (arb_owner >= 0) g[arb_owner] = 1'b1;
  endtask

  task automatic do_reset();
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0);
    arb_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (act_vec() !== 24'h0) $display("FAIL reset_outputs: got %h want %h", act_vec(), 24'h0);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_model: got %h want %h", act_vec(), exp_vec());
    else passes++;
  endtask

  task automatic test_single_job();
    logic [3:0] g;
    int nb = 0;
    do_reset();
    step(1'b1, 4'b0001, 4'h0);
    for (int k = 0; k < 12; k++) begin
      arb(g);
      step(1'b1, 4'h0, g);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL single_cyc%0d: got %h want %h", cyc, act_vec(), exp_vec());
      else passes++;
      if (beat_valid && beat_ch == 2'd0) nb++;
    end
    checks++;
    if (nb != 4) $display("FAIL single_beats: got %0d want 4", nb);
    else passes++;
    checks++;
    if (pend_cnt[2:0] !== 3'd0) $display("FAIL single_cnt: got %0d want 0", pend_cnt[2:0]);
    else passes++;
  endtask

  task automatic test_rotation();
    logic [3:0] g;
    int nb = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      arb(g);
      step(1'b1, 4'hF, g);
    end
    for (int k = 0; k < 120; k++) begin
      arb(g);
      step(1'b1, 4'h0, g);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL rot_cyc%0d: got %h want %h", cyc, act_vec(), exp_vec());
      else passes++;
      if (burst_done) begin
        checks++;
        if (beat_ch !== 2'(nb % 4)) $display("FAIL rot_order%0d: got ch%0d want ch%0d", nb, beat_ch, nb % 4);
        else passes++;
        nb++;
      end
    end
    checks++;
    if (nb != 12) $display("FAIL rot_bursts: got %0d want 12", nb);
    else passes++;
    checks++;
    if ({pend_cnt, ovf_err, proto_err} !== 14'h0) $display("FAIL rot_final: got %h want 0", {pend_cnt, ovf_err, proto_err});
    else passes++;
  endtask

  task automatic test_saturation();
    logic [3:0] g, p;
    bit hit = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0100, 4'h0);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL sat_cyc%0d: got %h want %h", cyc, act_vec(), exp_vec());
      else passes++;
    end
    checks++;
    if ({pend_cnt[8:6], ovf_err} !== 4'b1111) $display("FAIL sat_cnt_ovf: got %b want 1111", {pend_cnt[8:6], ovf_err});
    else passes++;
    for (int k = 0; k < 30; k++) begin
      p = (!hit && burst_done) ? 4'b0100 : 4'h0;
      arb(g);
      step(1'b1, p, g);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL sat_dec_cyc%0d: got %h want %h", cyc, act_vec(), exp_vec());
      else passes++;
      if (p != 0) begin
        hit = 1;
        checks++;
        if (pend_cnt[8:6] !== 3'd7) $display("FAIL sat_pulse_with_dec: got %0d want 7", pend_cnt[8:6]);
        else passes++;
      end
    end
    checks++;
    if (!hit) $display("FAIL sat_timeout: got no burst_done want one");
    else passes++;
  endtask

  task automatic test_bad_grants();
    do_reset();
    step(1'b1, 4'b0011, 4'h0);
    step(1'b1, 4'h0, 4'h0);
    step(1'b1, 4'h0, 4'b0011);
    checks++;
    if ({beat_valid, proto_err} !== 2'b01) $display("FAIL bad_multi: got %b want 01", {beat_valid, proto_err});
    else passes++;
    step(1'b1, 4'h0, 4'h0);
    checks++;
    if (act_vec() !== exp_vec()) $display("FAIL bad_multi_model: got %h want %h", act_vec(), exp_vec());
    else passes++;
    do_reset();
    step(1'b1, 4'h0, 4'b0100);
    checks++;
    if ({beat_valid, proto_err, REQ} !== 6'b010000) $display("FAIL bad_idle: got %b want 010000", {beat_valid, proto_err, REQ});
    else passes++;
  endtask

  task automatic test_grant_drop();
    logic [3:0] g;
    bit found = 0;
    do_reset();
    step(1'b1, 4'b0010, 4'h0);
    for (int k = 0; k < 20; k++) begin
      if (!found) begin
        if (beat_valid && beat_ch == 2'd1 && beat_idx == 2'd2) found = 1;
        else begin arb(g); step(1'b1, 4'h0, g); end
      end
    end
    checks++;
    if (!found) $display("FAIL drop_timeout: got no beat 2 want beat 2");
    else passes++;
    step(1'b1, 4'h0, 4'h0);
    checks++;
    if ({beat_valid, proto_err, REQ[1], pend_cnt[5:3]} !== 6'b010001)
      $display("FAIL drop_abort: got %b want 010001", {beat_valid, proto_err, REQ[1], pend_cnt[5:3]});
    else passes++;
    step(1'b1, 4'h0, 4'h0);
    step(1'b1, 4'h0, 4'h0);
    checks++;
    if (REQ !== 4'b0010) $display("FAIL drop_rereq: got %b want 0010", REQ);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec()) $display("FAIL drop_model: got %h want %h", act_vec(), exp_vec());
    else passes++;
  endtask

  task automatic test_reset_mid_xfer();
    logic [3:0] g;
    bit found = 0;
    do_reset();
    step(1'b1, 4'b1000, 4'h0);
    for (int k = 0; k < 20; k++) begin
      if (!found) begin
        if (beat_valid && beat_idx == 2'd1) found = 1;
        else begin arb(g); step(1'b1, 4'h0, g); end
      end
    end
    checks++;
    if (!found) $display("FAIL midrst_timeout: got no beat 1 want beat 1");
    else passes++;
    step(1'b0, 4'h0, 4'b1000);
    checks++;
    if (act_vec() !== 24'h0) $display("FAIL midrst_outputs: got %h want %h", act_vec(), 24'h0);
    else passes++;
  endtask

  task automatic test_random();
    logic [3:0] g, p;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      p = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      arb(g);
      if ($urandom_range(0, 59) == 0) g = 4'($urandom_range(0, 15));
      step(1'b1, p, g);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL rand_cyc%0d: got %h want %h", cyc, act_vec(), exp_vec());
      else passes++;
    end
  endtask

  initial begin
    rst_n = 1'b0; pend_in = 4'h0; GNT = 4'h0;
    model_reset();
    test_reset();
    test_single_job();
    test_rotation();
    test_saturation();
    test_bad_grants();
    test_grant_drop();
    test_reset_mid_xfer();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
